// File: rtl/reflet_int_to_float_seq_pkg.sv
// ============================================================================
// Module      : reflet_int_to_float_seq_pkg
// Description : Float field-width helpers and FSM state encoding for the
//               sequential integer-to-float converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reflet_int_to_float_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_NORM   = 2'd1,
        ST_ROUND  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    function automatic int exponent_size(input int float_size);
        case (float_size)
            16:      return 5;
            64:      return 11;
            default: return 8;
        endcase
    endfunction

    function automatic int mantissa_size(input int float_size);
        case (float_size)
            16:      return 10;
            64:      return 52;
            default: return 23;
        endcase
    endfunction

    function automatic int exponent_bias(input int float_size);
        return (1 << (exponent_size(float_size) - 1)) - 1;
    endfunction

    // All-ones exponent: infinity/NaN encoding, never a finite result
    function automatic int exponent_max(input int float_size);
        return (1 << exponent_size(float_size)) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reflet_int_to_float_seq_if.sv
// ============================================================================
// Module      : reflet_int_to_float_seq_if
// Description : Valid/ready operand and result bundle of the converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reflet_int_to_float_seq_if #(
    parameter int INT_SIZE   = 32,
    parameter int FLOAT_SIZE = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [INT_SIZE-1:0]   int_in;
    logic                  signed_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [FLOAT_SIZE-1:0] float_out;
    logic                  inexact;
    logic                  overflow;

    modport master (
        output in_valid, int_in, signed_mode, out_ready,
        input  in_ready, out_valid, float_out, inexact, overflow
    );

    modport slave (
        input  in_valid, int_in, signed_mode, out_ready,
        output in_ready, out_valid, float_out, inexact, overflow
    );
endinterface

`default_nettype wire

// File: rtl/reflet_int_to_float_seq_round.sv
// ============================================================================
// Module      : reflet_int_to_float_seq_round
// Description : Combinational rounding and exponent saturation stage.
//               REFLET_FLOAT_RNE_EN selects round-to-nearest-even; without
//               it the fraction is truncated toward zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reflet_int_to_float_seq_round
    import reflet_int_to_float_seq_pkg::*;
#(
    parameter int  FLOAT_SIZE = 32,
    localparam int c_exp_w    = exponent_size(FLOAT_SIZE),
    localparam int c_man_w    = mantissa_size(FLOAT_SIZE),
    localparam int c_exp_max  = exponent_max(FLOAT_SIZE)
)(
    input  wire logic [c_man_w-1:0] frac_i,
    input  wire logic               guard_i,
    input  wire logic               sticky_i,
    input  wire logic [31:0]        biased_i,
    output logic      [c_exp_w-1:0] exp_o,
    output logic      [c_man_w-1:0] frac_o,
    output logic                    inexact_o,
    output logic                    overflow_o
);

    logic               w_round_up;
    logic [c_man_w:0]   w_frac_inc;
    logic [31:0]        w_exp_adj;
    logic               w_ovf;

`ifdef REFLET_FLOAT_RNE_EN
    assign w_round_up = guard_i & (sticky_i | frac_i[0]);
`else
    assign w_round_up = 1'b0;
`endif

    // A carry out of the fraction leaves it all-zero and bumps the exponent
    assign w_frac_inc = {1'b0, frac_i} + {{c_man_w{1'b0}}, w_round_up};
    assign w_exp_adj  = biased_i + {31'b0, w_frac_inc[c_man_w]};
    assign w_ovf      = (w_exp_adj >= 32'(c_exp_max));

    assign exp_o      = w_ovf ? {c_exp_w{1'b1}} : w_exp_adj[c_exp_w-1:0];
    assign frac_o     = w_ovf ? {c_man_w{1'b0}} : w_frac_inc[c_man_w-1:0];
    assign inexact_o  = guard_i | sticky_i | w_ovf;
    assign overflow_o = w_ovf;

endmodule

`default_nettype wire

// File: rtl/reflet_int_to_float_seq.sv
// ============================================================================
// Module      : reflet_int_to_float_seq
// Description : Handshaked integer-to-float converter with a one-bit-per-cycle
//               normaliser; rounding mode set by REFLET_FLOAT_RNE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reflet_int_to_float_seq
    import reflet_int_to_float_seq_pkg::*;
#(
    parameter int INT_SIZE   = 32,
    parameter int FLOAT_SIZE = 32
)(
    input  wire logic               clk,
    input  wire logic               reset,
    reflet_int_to_float_seq_if.slave bus
);

    localparam int c_exp_w = exponent_size(FLOAT_SIZE);
    localparam int c_man_w = mantissa_size(FLOAT_SIZE);
    localparam int c_bias  = exponent_bias(FLOAT_SIZE);
    localparam int c_ec_w  = $clog2(INT_SIZE) + 1;
    localparam int c_ext_w = INT_SIZE + c_man_w + 1;

    localparam logic [c_ec_w-1:0] c_ec_one  = {{(c_ec_w-1){1'b0}}, 1'b1};
    localparam logic [c_ec_w-1:0] c_ec_init = c_ec_w'(INT_SIZE - 1);

    state_t                state_q,    state_d;
    logic                  sign_q,     sign_d;
    logic [INT_SIZE-1:0]   mag_q,      mag_d;
    logic [c_ec_w-1:0]     exp_cnt_q,  exp_cnt_d;
    logic [FLOAT_SIZE-1:0] float_q,    float_d;
    logic                  inexact_q,  inexact_d;
    logic                  overflow_q, overflow_d;

    logic                  w_sign_in;
    logic [INT_SIZE-1:0]   w_mag_in;
    logic [c_ext_w-1:0]    w_ext;
    logic [c_man_w-1:0]    w_frac;
    logic                  w_guard;
    logic                  w_sticky;
    logic [31:0]           w_biased;
    logic [c_exp_w-1:0]    w_rnd_exp;
    logic [c_man_w-1:0]    w_rnd_frac;
    logic                  w_rnd_inexact;
    logic                  w_rnd_overflow;

    // Negating the most negative value wraps to 2^(INT_SIZE-1), its true magnitude
    assign w_sign_in = bus.signed_mode & bus.int_in[INT_SIZE-1];
    assign w_mag_in  = w_sign_in ? -bus.int_in : bus.int_in;

    // Hidden bit dropped; zero tail pads short integers and feeds guard/sticky
    assign w_ext    = {mag_q[INT_SIZE-2:0], {(c_man_w + 2){1'b0}}};
    assign w_frac   = w_ext[c_ext_w-1 -: c_man_w];
    assign w_guard  = w_ext[c_ext_w-1-c_man_w];
    assign w_sticky = |w_ext[c_ext_w-2-c_man_w:0];
    assign w_biased = 32'(exp_cnt_q) + 32'(c_bias);

    reflet_int_to_float_seq_round #(
        .FLOAT_SIZE (FLOAT_SIZE)
    ) u_round (
        .frac_i     (w_frac),
        .guard_i    (w_guard),
        .sticky_i   (w_sticky),
        .biased_i   (w_biased),
        .exp_o      (w_rnd_exp),
        .frac_o     (w_rnd_frac),
        .inexact_o  (w_rnd_inexact),
        .overflow_o (w_rnd_overflow)
    );

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        mag_d      = mag_q;
        exp_cnt_d  = exp_cnt_q;
        float_d    = float_q;
        inexact_d  = inexact_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    sign_d    = w_sign_in;
                    mag_d     = w_mag_in;
                    exp_cnt_d = c_ec_init;
                    if (w_mag_in == '0) begin
                        float_d    = '0;
                        inexact_d  = 1'b0;
                        overflow_d = 1'b0;
                        state_d    = ST_OUTPUT;
                    end else begin
                        state_d    = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                if (mag_q[INT_SIZE-1]) begin
                    state_d = ST_ROUND;
                end else begin
                    mag_d     = {mag_q[INT_SIZE-2:0], 1'b0};
                    exp_cnt_d = exp_cnt_q - c_ec_one;
                end
            end
            ST_ROUND: begin
                float_d    = {sign_q, w_rnd_exp, w_rnd_frac};
                inexact_d  = w_rnd_inexact;
                overflow_d = w_rnd_overflow;
                state_d    = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sign_q     <= 1'b0;
            mag_q      <= '0;
            exp_cnt_q  <= '0;
            float_q    <= '0;
            inexact_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            mag_q      <= mag_d;
            exp_cnt_q  <= exp_cnt_d;
            float_q    <= float_d;
            inexact_q  <= inexact_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_OUTPUT);
    assign bus.float_out = float_q;
    assign bus.inexact   = inexact_q;
    assign bus.overflow  = overflow_q;

endmodule

`default_nettype wire
